// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = WORD_W / 8;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        LD_HDR,
        LD_DATA,
        LD_SUM,
        LD_DONE,
        LD_ERR
    } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; the completed word is
// presented combinationally in the cycle its last byte is accepted.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    logic [BYTE_CNT_W-1:0] cnt_q;
    logic [WORD_W-1:0]     asm_q;

    // New byte enters at the top; after four shifts the first byte sits at bits [7:0].
    assign word_c       = {byte_data, asm_q[WORD_W-1:8]};
    assign word_valid_c = byte_valid && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (byte_valid) begin
            cnt_q <= cnt_q + BYTE_CNT_W'(1);
            asm_q <= word_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses header / words / checksum from a byte stream, writes
// instruction memory from address 0 and releases the core once verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter int unsigned IMEM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_valid,
    input  logic [7:0]                    s_data,
    output logic                          s_ready,
    input  logic                          reload,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [IMEM_WIDTH-1:0]         imem_wdata,
    output logic                          core_rst_n,
    output logic                          done,
    output logic                          error
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);
    localparam int unsigned CW = $clog2(IMEM_DEPTH + 1);

    loader_state_e     state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     n_q, n_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic              we_d;
    logic [AW-1:0]     waddr_d;
    logic [IMEM_WIDTH-1:0] wdata_d;
    logic              clr_c;
    logic              accept_c;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;

    assign s_ready  = (state_q == LD_HDR) || (state_q == LD_DATA) || (state_q == LD_SUM);
    assign accept_c = s_valid && s_ready;

    byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr_c),
        .byte_valid   (accept_c),
        .byte_data    (s_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next-state, bookkeeping and write-port decode; decisions use the word
    // completing this cycle so results appear one cycle after its last byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        waddr_d = imem_waddr;
        wdata_d = imem_wdata;
        clr_c   = 1'b0;

        case (state_q)
            LD_HDR: begin
                if (word_valid_c) begin
                    if (word_c == '0) begin
                        n_d     = '0;
                        sum_d   = '0;
                        state_d = LD_SUM;
                    end else if (word_c > WORD_W'(IMEM_DEPTH)) begin
                        state_d = LD_ERR;
                    end else begin
                        n_d     = CW'(word_c);
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (word_valid_c) begin
                    we_d    = 1'b1;
                    waddr_d = AW'(idx_q);
                    wdata_d = IMEM_WIDTH'(word_c);
                    idx_d   = idx_q + CW'(1);
                    sum_d   = sum_q + word_c;
                    if (idx_d == n_q) begin
                        state_d = LD_SUM;
                    end
                end
            end
            LD_SUM: begin
                if (word_valid_c) begin
                    state_d = (word_c == sum_q) ? LD_DONE : LD_ERR;
                end
            end
            LD_DONE: begin
                if (reload) begin
                    idx_d   = '0;
                    n_d     = '0;
                    sum_d   = '0;
                    state_d = LD_HDR;
                end
            end
            LD_ERR: begin
                state_d = LD_ERR;
            end
            default: begin
                state_d = LD_ERR;
            end
        endcase

        clr_c = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LD_HDR;
            idx_q      <= '0;
            n_q        <= '0;
            sum_q      <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            sum_q      <= sum_d;
            imem_we    <= we_d;
            imem_waddr <= waddr_d;
            imem_wdata <= wdata_d;
            core_rst_n <= (state_d == LD_DONE);
            done       <= (state_d == LD_DONE);
            error      <= (state_d == LD_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a stream-level model predicts writes,
// their cycles, and the final done/error outcome of each load.
module tb_imem_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        reload;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;

    imem_loader #(.IMEM_DEPTH(DEPTH), .IMEM_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t         got_q[$];
    int unsigned exp_cyc_q[$];
    int          n_total = 0;
    int          n_bad   = 0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) got_q.push_back('{32'(imem_waddr), imem_wdata, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_rdy"},  32'(s_ready),    32'd1);
        check({tag, "_we"},   32'(imem_we),    32'd0);
        check({tag, "_addr"}, 32'(imem_waddr), 32'd0);
        check({tag, "_data"}, imem_wdata,      32'd0);
        check({tag, "_crst"}, 32'(core_rst_n), 32'd0);
        check({tag, "_done"}, 32'(done),       32'd0);
        check({tag, "_err"},  32'(error),      32'd0);
    endtask

    // Drives bytes with random idle gaps; records the acceptance cycle of each data word's last byte.
    task automatic send_bytes(input logic [7:0] b[$], input int gap_pct,
                              input int data_lo, input int data_hi, output int not_ready);
        not_ready = 0;
        foreach (b[i]) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = b[i];
            if (s_ready !== 1'b1) not_ready++;
            @(posedge clk);
            #1;
            if (i >= data_lo && i < data_hi && (i % 4) == 3) exp_cyc_q.push_back(cyc);
            s_valid = 1'b0;
        end
    endtask

    task automatic run_load(input int n, input logic [31:0] w[$], input logic [31:0] csum,
                            input int gap_pct, input string tag, output bit exp_done);
        logic [7:0]  b[$];
        logic [31:0] sum;
        logic [31:0] hdr;
        int          nr;
        int          n_exp;
        bit          ok_len;
        got_q.delete();
        exp_cyc_q.delete();
        hdr    = 32'(n);
        ok_len = (n <= DEPTH);
        for (int k = 0; k < 4; k++) b.push_back(hdr[8*k +: 8]);
        sum = '0;
        if (ok_len) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] wi;
                wi  = w[i];
                sum = sum + wi;
                for (int k = 0; k < 4; k++) b.push_back(wi[8*k +: 8]);
            end
            for (int k = 0; k < 4; k++) b.push_back(csum[8*k +: 8]);
        end
        exp_done = ok_len && (sum == csum);
        n_exp    = ok_len ? n : 0;
        send_bytes(b, gap_pct, 4, 4 + 4 * n_exp, nr);
        check({tag, "_notrdy"}, 32'(nr),         32'd0);
        check({tag, "_done"},   32'(done),       32'(exp_done));
        check({tag, "_err"},    32'(error),      32'(!exp_done));
        check({tag, "_crst"},   32'(core_rst_n), 32'(exp_done));
        check({tag, "_srdy"},   32'(s_ready),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_nwr"}, 32'(got_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
            check($sformatf("%s_a%0d", tag, i), got_q[i].addr, 32'(i));
            check($sformatf("%s_d%0d", tag, i), got_q[i].data, w[i]);
            if (i < exp_cyc_q.size())
                check($sformatf("%s_c%0d", tag, i), 32'(got_q[i].cyc), 32'(exp_cyc_q[i]));
        end
    endtask

    task automatic pulse_reload(input string tag);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check({tag, "_crst"}, 32'(core_rst_n), 32'd0);
        check({tag, "_done"}, 32'(done),       32'd0);
        check({tag, "_srdy"}, 32'(s_ready),    32'd1);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk_reset(tag);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] t1[$];
        logic [31:0] wq[$];
        logic [7:0]  pb[$];
        logic [31:0] csum;
        bit          ed;
        int          nr;
        int          n;

        s_valid = 1'b0;
        s_data  = '0;
        reload  = 1'b0;
        reset_n = 1'b0;
        #2;
        chk_reset("por");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        t1.push_back(32'h0000_0013);
        t1.push_back(32'h00A0_0093);

        run_load(2, t1, 32'h00A0_00A6, 0, "t1", ed);
        pulse_reload("rl1");
        run_load(2, t1, 32'h00A0_00A6, 40, "gap", ed);
        pulse_reload("rl2");

        wq.delete();
        run_load(0, wq, 32'h0, 0, "n0", ed);
        pulse_reload("rl3");

        run_load(33, wq, 32'h0, 0, "n33", ed);
        repeat (5) @(posedge clk);
        #1;
        check("n33_hold_crst", 32'(core_rst_n), 32'd0);
        check("n33_hold_err",  32'(error),      32'd1);
        do_reset("rst1");

        wq.delete();
        wq.push_back(32'h1234_5678);
        run_load(1, wq, 32'h1234_5679, 0, "bad", ed);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bad_rl_err",  32'(error),      32'd1);
        check("bad_rl_done", 32'(done),       32'd0);
        check("bad_rl_srdy", 32'(s_ready),    32'd0);
        check("bad_rl_crst", 32'(core_rst_n), 32'd0);
        do_reset("rst2");

        // Async reset in the middle of word 0 must discard progress immediately.
        run_load(2, t1, 32'h00A0_00A6, 0, "pre", ed);
        pulse_reload("rl4");
        pb.delete();
        pb.push_back(8'd3); pb.push_back(8'd0); pb.push_back(8'd0); pb.push_back(8'd0);
        pb.push_back(8'h13); pb.push_back(8'h00);
        send_bytes(pb, 0, 0, 0, nr);
        check("mid_notrdy", 32'(nr), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("mid");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_load(2, t1, 32'h00A0_00A6, 20, "fresh", ed);
        pulse_reload("rl5");

        for (int it = 0; it < 12; it++) begin
            n = int'($urandom_range(0, 35));
            wq.delete();
            csum = '0;
            for (int i = 0; i < n; i++) begin
                logic [31:0] r;
                r = $urandom;
                wq.push_back(r);
                csum = csum + r;
            end
            if ($urandom_range(4) == 0) csum = csum ^ 32'h0000_0100;
            run_load(n, wq, csum, int'($urandom_range(0, 50)), $sformatf("rnd%0d", it), ed);
            if (ed) pulse_reload($sformatf("rrl%0d", it));
            else    do_reset($sformatf("rrs%0d", it));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It receives a little-endian byte stream over a valid/ready interface and packs the bytes into 32-bit words. It writes those words into instruction memory from address 0 and checks a trailing checksum. It holds the RV32 core in reset until a complete, verified image is loaded. It sits between the external boot link and the write port of `instruction_memory`; the core's fetch path reads what this block writes.

## Interface
Parameters:
- `IMEM_DEPTH`, 32: instruction memory depth in words.
- `IMEM_WIDTH`, 32: word width; only 32 is supported (4 bytes per word).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  byte available on `s_data`.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  block accepts byte; transfer when `s_valid & s_ready`.
- `reload`  in  1  in DONE only: restart the load sequence.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_waddr`  out  $clog2(IMEM_DEPTH)  word address.
- `imem_wdata`  out  IMEM_WIDTH  word to write.
- `core_rst_n`  out  1  active-low reset to the core; high only in DONE.
- `done`  out  1  image loaded and verified.
- `error`  out  1  length or checksum fault; sticky.

## Operation
- Stream format, all fields 32-bit little-endian:
  - word count N;
  - N instruction words;
  - checksum = sum of the N words modulo 2^32.
- States: LD_HDR → LD_DATA → LD_SUM → LD_DONE. Any state can go to LD_ERR.
- LD_HDR: collect 4 bytes into N.
  - N == 0 → LD_SUM.
  - N > IMEM_DEPTH → LD_ERR.
  - Otherwise → LD_DATA, with word index and running sum cleared.
- LD_DATA: each 4th accepted byte completes a word.
  - Issue the write at word index k, then k++.
  - Add the word to the running sum (32-bit wrap).
  - After word N-1 → LD_SUM.
- LD_SUM: collect 4 bytes; compare with the running sum.
  - Equal → LD_DONE.
  - Otherwise → LD_ERR.
- LD_DONE: `done`=1, `core_rst_n`=1.
  - `reload`=1 → LD_HDR; clear index, sum, and byte counter; `done`=0 and `core_rst_n`=0.
- LD_ERR: `error`=1, `core_rst_n`=0. Exit only via `reset_n`.
- `reload` is ignored outside LD_DONE.
- `s_ready` is combinational from state: 1 in LD_HDR, LD_DATA, and LD_SUM; 0 in LD_DONE and LD_ERR.
- Reset values:
  - state LD_HDR, so `s_ready` is 1 after release;
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0;
  - `core_rst_n`=0, `done`=0, `error`=0;
  - byte counter, word index, and sum all 0.
- Reset mid-load: the partial word and all progress are discarded. Memory contents already written are left untouched, because this block does not own them.

## Timing
- A byte is accepted in any cycle with `s_valid & s_ready`. Gaps of any length are allowed, and there is no backpressure inside a load.
- When the 4th byte of word k is accepted in cycle t, the block drives `imem_we`=1, `imem_waddr`=k, and `imem_wdata`=word in cycle t+1, for exactly one cycle.
  - `imem_waddr` and `imem_wdata` hold their values until the next write.
  - Back-to-back words can produce writes 4 cycles apart.
- Header 4th byte accepted in cycle t → the new state is visible in t+1. The LD_ERR case for N > IMEM_DEPTH also shows `error`=1 in t+1.
- Checksum 4th byte accepted in cycle t → one of the following in t+1:
  - `done`=1 and `core_rst_n`=1; or
  - `error`=1.
- The last data write (cycle t+1 of its word) always comes before the LD_SUM decision.
- `reload` sampled high in LD_DONE in cycle t → `core_rst_n`=0, `done`=0, and `s_ready`=1 in t+1.
- All outputs are registered except `s_ready`.

## Structure
- Package `imem_loader_pkg`:
  - `loader_state_e` enum {LD_HDR, LD_DATA, LD_SUM, LD_DONE, LD_ERR};
  - `BYTES_PER_WORD` = IMEM_WIDTH/8.
- Sub-module `byte_packer`:
  - 2-bit byte counter plus a 32-bit little-endian shift/assemble register;
  - emits a one-cycle `word_valid` and `word`;
  - has a synchronous clear used on state changes and on reload.
- Top: FSM, word index, remaining-word compare, checksum accumulator, and the write-port registers.

## Test plan
- Stream N=2, words 0x00000013 and 0x00A00093, checksum 0x00A000A6:
  - required: writes addr0=0x00000013 and addr1=0x00A00093;
  - `done`=1 and `core_rst_n`=1 one cycle after the last checksum byte.
- Stream N=0, checksum 0 → LD_DONE with no `imem_we` pulse.
- Stream N=33 with IMEM_DEPTH=32 → `error`=1 one cycle after the header, `s_ready`=0, no writes, `core_rst_n` stays 0.
- N=1, word 0x12345678, checksum 0x12345679:
  - the write occurs;
  - then `error`=1 and `done`=0;
  - a subsequent `reload` pulse has no effect.
- The first test's stream with `s_valid` randomly deasserted between bytes → identical writes and the same final state.
- Two separate runs, each ending in a fresh full load:
  - run 1: after the first test completes, pulse `reload`; required `core_rst_n`=0 next cycle;
  - run 2: assert `reset_n` low after 2 bytes of word 0; required all outputs at reset values immediately, without a clock edge;
  - after each run, a fresh full load writes from addr 0 and finishes with `done`=1.
